mem_access_unit: RTL and testbench

- MEM-stage data-memory access controller for the 16-bit pipeline.
- Sits between the EX_MEM pipeline register and the MEM_WB register.
- Turns an EX_MEM load/store into a request/acknowledge transaction on a variable-latency data memory.
- Stalls the pipeline until the access completes and presents load data for MEM_WB's IStoreMem input.

---
 rtl/miscv_pkg.sv | 14 +
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/miscv_pkg.sv
// Shared definitions for the 16-bit pipeline's MEM-stage blocks:
// data/address widths and the memory access FSM state encoding.
package miscv_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller.
// Converts an EX_MEM load/store into a request/acknowledge transaction on a
// variable-latency data memory, stalls the pipeline until it completes and
// holds the last loaded word for MEM_WB.
// Optional feature: define MEM_ALIGN_CHECK_EN to add the OMisaligned output;
// an odd address then completes without issuing a memory request.
module mem_access_unit
  import miscv_pkg::*;
#(
  parameter int DATA_W = miscv_pkg::DATA_W,
  parameter int ADDR_W = miscv_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IValid,
  input  logic              IMemRead,
  input  logic              IMemWrite,
  input  logic [ADDR_W-1:0] IAddr,
  input  logic [DATA_W-1:0] IWriteData,
  output logic              MReq,
  output logic              MWe,
  output logic [ADDR_W-1:0] MAddr,
  output logic [DATA_W-1:0] MWData,
  input  logic              MAck,
  input  logic [DATA_W-1:0] MRData,
  output logic [DATA_W-1:0] OLoadData,
  output logic              OStall,
  output logic              ODone
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              OMisaligned
`endif
);

  mem_state_t        state_r;
  mem_state_t        state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic              we_r;
  logic [DATA_W-1:0] load_data_r;
  logic              start_s;

  // A live instruction that touches memory; a load+store combination is a store.
  assign start_s = IValid & (IMemRead | IMemWrite);

  // Next-state decode; DONE always returns to IDLE so the same instruction,
  // still present on the inputs during DONE, cannot restart an access.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
`ifdef MEM_ALIGN_CHECK_EN
          if (IAddr[0]) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = REQ;
          end
`else
          state_nxt_s = REQ;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (MAck) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, request latches and load-data register; acks outside REQ are ignored.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      we_r        <= 1'b0;
      load_data_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            addr_r  <= IAddr;
            wdata_r <= IWriteData;
            we_r    <= IMemWrite;
          end
        end
        REQ: begin
          if (MAck && !we_r) begin
            load_data_r <= MRData;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned_r;

  // Flags an odd-address access for exactly the DONE cycle it produces.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      misaligned_r <= 1'b0;
    end else if ((state_r == IDLE) && start_s && IAddr[0]) begin
      misaligned_r <= 1'b1;
    end else begin
      misaligned_r <= 1'b0;
    end
  end

  assign OMisaligned = misaligned_r;
`endif

  // Memory-side outputs come straight from the state and latch registers so
  // they stay stable for the whole REQ phase.
  assign MReq      = (state_r == REQ);
  assign MWe       = (state_r == REQ) & we_r;
  assign MAddr     = addr_r;
  assign MWData    = wdata_r;
  assign OLoadData = load_data_r;
  assign ODone     = (state_r == DONE);

  // Stall covers the start cycle and every REQ cycle; it drops in DONE so the
  // pipeline advances on the DONE edge, and is forced low during reset.
  assign OStall = ~Reset & (((state_r == IDLE) & start_s) | (state_r == REQ));

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit. The bench plays the data
// memory; expected load data is queued when an access is launched and popped
// when the DUT signals completion.
module tb_mem_access_unit;

  logic        CLK;
  logic        Reset;
  logic        IValid;
  logic        IMemRead;
  logic        IMemWrite;
  logic [15:0] IAddr;
  logic [15:0] IWriteData;
  logic        MReq;
  logic        MWe;
  logic [15:0] MAddr;
  logic [15:0] MWData;
  logic        MAck;
  logic [15:0] MRData;
  logic [15:0] OLoadData;
  logic        OStall;
  logic        ODone;
`ifdef MEM_ALIGN_CHECK_EN
  logic        OMisaligned;
`endif

  int          vectors;
  int          miscompares;
  logic [15:0] model_load;
  logic [15:0] sb[$];

  mem_access_unit dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .IValid     (IValid),
    .IMemRead   (IMemRead),
    .IMemWrite  (IMemWrite),
    .IAddr      (IAddr),
    .IWriteData (IWriteData),
    .MReq       (MReq),
    .MWe        (MWe),
    .MAddr      (MAddr),
    .MWData     (MWData),
    .MAck       (MAck),
    .MRData     (MRData),
    .OLoadData  (OLoadData),
    .OStall     (OStall),
    .ODone      (ODone)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .OMisaligned(OMisaligned)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete access, entered 1 time unit after the edge that lands in IDLE.
  // The memory acks after 'waits' extra REQ cycles.
  task automatic access(input logic wr, input logic rd, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdata,
                        input int waits);
    int stalls;
    logic [15:0] exp;
    IValid     = 1'b1;
    IMemRead   = rd;
    IMemWrite  = wr;
    IAddr      = addr;
    IWriteData = wdata;
    MAck       = 1'b0;
    MRData     = 16'hDEAD;
    #1;
    chk1("idle_mreq", MReq, 1'b0);
    chk1("idle_stall", OStall, 1'b1);
    chk16("idle_hold", OLoadData, model_load);
    if (wr) exp = model_load;
    else exp = rdata;
    model_load = exp;
    sb.push_back(exp);
    stalls = 1;
    for (int w = 0; w <= waits; w++) begin
      tick();
      chk1("req_mreq", MReq, 1'b1);
      chk16("req_maddr", MAddr, addr);
      chk1("req_mwe", MWe, wr);
      if (wr) chk16("req_mwdata", MWData, wdata);
      MAck   = (w == waits);
      MRData = (w == waits) ? rdata : 16'hDEAD;
      #1;
      chk1("req_stall", OStall, 1'b1);
      stalls++;
    end
    tick();
    MAck   = 1'b0;
    MRData = 16'hDEAD;
    chk1("done_pulse", ODone, 1'b1);
    chk1("done_mreq", MReq, 1'b0);
    chk1("done_stall", OStall, 1'b0);
    chk16("load_data", OLoadData, sb.pop_front());
    chk16("stall_len", 16'(stalls), 16'(waits + 2));
    tick();
    chk1("done_clear", ODone, 1'b0);
  endtask

  // Watchdog in case simulation time runs away.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_load  = 16'h0000;
    Reset       = 1'b1;
    IValid      = 1'b1;
    IMemRead    = 1'b1;
    IMemWrite   = 1'b0;
    IAddr       = 16'h1234;
    IWriteData  = 16'h0000;
    MAck        = 1'b0;
    MRData      = 16'h0000;

    // Reset held two cycles with a load presented.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk1("rst_mreq", MReq, 1'b0);
      chk1("rst_mwe", MWe, 1'b0);
      chk16("rst_maddr", MAddr, 16'h0000);
      chk16("rst_mwdata", MWData, 16'h0000);
      chk16("rst_load", OLoadData, 16'h0000);
      chk1("rst_done", ODone, 1'b0);
      chk1("rst_stall", OStall, 1'b0);
    end
    Reset  = 1'b0;
    IValid = 1'b0;
    tick();

    // Load with two wait cycles, then store with immediate ack.
    access(1'b0, 1'b1, 16'h0040, 16'h0000, 16'h9ABC, 2);
    access(1'b1, 1'b0, 16'h0100, 16'h5678, 16'hDEAD, 0);
    chk16("store_keeps_load", OLoadData, 16'h9ABC);

    // Non-memory instruction and an invalid load: no stall, no request.
    IValid = 1'b1; IMemRead = 1'b0; IMemWrite = 1'b0;
    #1;
    chk1("nonmem_stall", OStall, 1'b0);
    tick();
    chk1("nonmem_mreq", MReq, 1'b0);
    IValid = 1'b0; IMemRead = 1'b1;
    #1;
    chk1("invalid_stall", OStall, 1'b0);
    MAck = 1'b1; MRData = 16'hBEEF;
    tick();
    MAck = 1'b0;
    chk1("invalid_mreq", MReq, 1'b0);
    chk1("stray_ack_done", ODone, 1'b0);
    chk16("stray_ack_load", OLoadData, 16'h9ABC);

    // Reset while in REQ, followed by a stray ack.
    IValid = 1'b1; IMemRead = 1'b1; IMemWrite = 1'b0; IAddr = 16'h0200;
    tick();
    chk1("rreq_mreq", MReq, 1'b1);
    Reset = 1'b1;
    #1;
    chk1("rreq_stall", OStall, 1'b0);
    tick();
    Reset = 1'b0; IValid = 1'b0; IMemRead = 1'b0;
    chk1("rreq_mreq_off", MReq, 1'b0);
    chk16("rreq_load", OLoadData, 16'h0000);
    MAck = 1'b1; MRData = 16'hFFFF;
    tick();
    MAck = 1'b0;
    chk1("rreq_no_done", ODone, 1'b0);
    chk16("rreq_load_hold", OLoadData, 16'h0000);
    chk1("rreq_mreq_idle", MReq, 1'b0);
    model_load = 16'h0000;

    // Back-to-back loads; the second starts in the IDLE gap after DONE.
    access(1'b0, 1'b1, 16'h0002, 16'h0000, 16'h1111, 0);
    access(1'b0, 1'b1, 16'h0004, 16'h0000, 16'h2222, 0);

    // Load+store together behaves as a store.
    access(1'b1, 1'b1, 16'h0006, 16'hA5A5, 16'h7777, 1);
    chk16("both_keeps_load", OLoadData, 16'h2222);

    // Odd address.
`ifdef MEM_ALIGN_CHECK_EN
    IValid = 1'b1; IMemRead = 1'b1; IMemWrite = 1'b0; IAddr = 16'h0003;
    #1;
    chk1("mis_stall", OStall, 1'b1);
    chk1("mis_idle_mreq", MReq, 1'b0);
    tick();
    chk1("mis_done", ODone, 1'b1);
    chk1("mis_flag", OMisaligned, 1'b1);
    chk1("mis_mreq", MReq, 1'b0);
    chk1("mis_done_stall", OStall, 1'b0);
    chk16("mis_load", OLoadData, 16'h2222);
    IValid = 1'b0;
    tick();
    chk1("mis_flag_clear", OMisaligned, 1'b0);
    chk1("mis_after_mreq", MReq, 1'b0);
`else
    access(1'b0, 1'b1, 16'h0003, 16'h0000, 16'h3333, 1);
`endif
    IValid = 1'b0;
    tick();
    chk1("final_mreq", MReq, 1'b0);
    chk1("final_stall", OStall, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
